// File: rtl/aes_req_sched_if.sv
// rtl/aes_req_sched_if.sv - requester/response bundle for the AES request scheduler
// Purpose : groups both requester handshakes and the tagged response outputs.
// Signals : req0_*/req1_* valid/ready/state/key per requester;
//           rsp0_valid/rsp1_valid one-cycle ownership pulses; rsp_data ciphertext.
// master  : requester side (drives valid/state/key, observes ready/responses).
// slave   : scheduler side.
interface aes_req_sched_if;
    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_state;
    logic [127:0] req0_key;
    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_state;
    logic [127:0] req1_key;
    logic         rsp0_valid;
    logic         rsp1_valid;
    logic [127:0] rsp_data;

    modport master (
        output req0_valid, req0_state, req0_key,
        output req1_valid, req1_state, req1_key,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data
    );

    modport slave (
        input  req0_valid, req0_state, req0_key,
        input  req1_valid, req1_state, req1_key,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data
    );
endinterface

// File: rtl/aes_req_sched.sv
// rtl/aes_req_sched.sv - shares one pipelined AES-128 core between two requesters
// Purpose : per-block arbitration, registered core inputs, tag pipe that routes
//           each result back to its requester LATENCY cycles after issue.
// Ports   : clk, rst (sync, active-high); req_if (slave modport: requests and
//           responses); core_state/core_key to the core; core_out from the core;
//           inflight outstanding-block count; busy = inflight != 0.
// Macro   : AES_SCHED_STRICT_PRIO_EN - req0 always wins; otherwise round-robin.
module aes_req_sched #(
    parameter int LATENCY      = 21,
    parameter int MAX_INFLIGHT = 21,
    parameter int CNT_W        = 5
) (
    input  logic               clk,
    input  logic               rst,
    aes_req_sched_if.slave     req_if,
    output logic [127:0]       core_state,
    output logic [127:0]       core_key,
    input  logic [127:0]       core_out,
    output logic [CNT_W-1:0]   inflight,
    output logic               busy
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [127:0]       core_state_q, core_state_d;
    logic [127:0]       core_key_q, core_key_d;
    logic [127:0]       rsp_data_q, rsp_data_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    // Index 0 is stage 1; index LATENCY-1 is the stage that retires.
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;

    logic gnt0, gnt1, cap_ok, issue, issue_id, retire, retire_id;

    assign retire    = tag_vld_q[LATENCY-1];
    assign retire_id = tag_id_q[LATENCY-1];
    // A retiring slot frees capacity for a same-cycle issue.
    assign cap_ok    = (inflight_q < MAX_CNT) || retire;

`ifdef AES_SCHED_STRICT_PRIO_EN
    assign gnt0 = req_if.req0_valid;
    assign gnt1 = req_if.req1_valid & ~req_if.req0_valid;
`else
    logic rr_last_q, rr_last_d;

    // On contention the requester that did not win last is granted.
    assign gnt0 = req_if.req0_valid & (~req_if.req1_valid | rr_last_q);
    assign gnt1 = req_if.req1_valid & (~req_if.req0_valid | ~rr_last_q);
    assign rr_last_d = issue ? issue_id : rr_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign req_if.req0_ready = gnt0 & cap_ok;
    assign req_if.req1_ready = gnt1 & cap_ok;
    assign issue    = req_if.req0_ready | req_if.req1_ready;
    assign issue_id = req_if.req1_ready;

    always_comb begin
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (issue) begin
            core_state_d = issue_id ? req_if.req1_state : req_if.req0_state;
            core_key_d   = issue_id ? req_if.req1_key   : req_if.req0_key;
        end

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = issue_id;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        rsp0_valid_d = retire & ~retire_id;
        rsp1_valid_d = retire & retire_id;
        rsp_data_d   = retire ? core_out : rsp_data_q;

        inflight_d = inflight_q;
        if (issue && !retire) begin
            inflight_d = inflight_q + ONE;
        end else if (!issue && retire) begin
            inflight_d = inflight_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_state_q <= '0;
            core_key_q   <= '0;
            rsp_data_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            inflight_q   <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
        end else begin
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            rsp_data_q   <= rsp_data_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            inflight_q   <= inflight_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
        end
    end

    assign core_state        = core_state_q;
    assign core_key          = core_key_q;
    assign req_if.rsp0_valid = rsp0_valid_q;
    assign req_if.rsp1_valid = rsp1_valid_q;
    assign req_if.rsp_data   = rsp_data_q;
    assign inflight          = inflight_q;
    assign busy              = inflight_q != '0;
endmodule

// File: tb/tb_aes_req_sched.sv
// tb/tb_aes_req_sched.sv - self-checking bench for aes_req_sched
module tb_aes_req_sched;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        bit           id;
        int           due;
        logic [127:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_s [2];
    logic         v0_s [2];
    logic         v1_s [2];
    logic [127:0] s0_s [2];
    logic [127:0] k0_s [2];
    logic [127:0] s1_s [2];
    logic [127:0] k1_s [2];
    logic         r0_w [2];
    logic         r1_w [2];
    logic         p0_w [2];
    logic         p1_w [2];
    logic [127:0] rd_w [2];
    logic [4:0]   inf_w [2];

    // Stand-in core function: the real FIPS-197 vector plus a reversible mix otherwise.
    function automatic logic [127:0] f_core(input logic [127:0] s, input logic [127:0] k);
        if (s == PT && k == KEY) return CT;
        return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_1234_5678_9abc_def0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int L = (g == 0) ? 21 : 8;
        localparam int M = (g == 0) ? 21 : 4;

        aes_req_sched_if bus ();
        logic [127:0] core_state, core_key, core_out;
        logic [4:0]   inflight;
        logic         busy;

        assign bus.req0_valid = v0_s[g];
        assign bus.req0_state = s0_s[g];
        assign bus.req0_key   = k0_s[g];
        assign bus.req1_valid = v1_s[g];
        assign bus.req1_state = s1_s[g];
        assign bus.req1_key   = k1_s[g];
        assign r0_w[g]  = bus.req0_ready;
        assign r1_w[g]  = bus.req1_ready;
        assign p0_w[g]  = bus.rsp0_valid;
        assign p1_w[g]  = bus.rsp1_valid;
        assign rd_w[g]  = bus.rsp_data;
        assign inf_w[g] = inflight;

        aes_req_sched #(.LATENCY(L), .MAX_INFLIGHT(M), .CNT_W(5)) dut (
            .clk        (clk),
            .rst        (rst_s[g]),
            .req_if     (bus),
            .core_state (core_state),
            .core_key   (core_key),
            .core_out   (core_out),
            .inflight   (inflight),
            .busy       (busy)
        );

        // Core model: output reflects the inputs registered L-1 edges earlier.
        logic [127:0] cpipe [1:L-1];
        always @(posedge clk) begin
            cpipe[1] <= f_core(core_state, core_key);
            for (int i = 2; i < L; i++) cpipe[i] <= cpipe[i-1];
        end
        assign core_out = cpipe[L-1];

        // Reference model: a queue of outstanding blocks, each due L edges after accept.
        ent_t         q [$];
        bit           rr_last = 1'b1;
        logic [127:0] exp_cs = '0, exp_ck = '0, exp_rd = '0;
        always @(negedge clk) begin
            int   n;
            bit   cap, g0, g1;
            ent_t e;
            n = cyc;
            if (q.size() > 0 && q[0].due == n) begin
                e = q.pop_front();
                exp_rd = e.data;
                chk($sformatf("i%0d rsp0_valid", g), 128'(p0_w[g]), 128'(!e.id));
                chk($sformatf("i%0d rsp1_valid", g), 128'(p1_w[g]), 128'(e.id));
            end else begin
                chk($sformatf("i%0d rsp0_idle", g), 128'(p0_w[g]), 128'(0));
                chk($sformatf("i%0d rsp1_idle", g), 128'(p1_w[g]), 128'(0));
            end
            chk($sformatf("i%0d rsp_data", g), rd_w[g], exp_rd);
            chk($sformatf("i%0d inflight", g), 128'(inflight), 128'(q.size()));
            chk($sformatf("i%0d busy", g), 128'(busy), 128'(q.size() != 0));
            chk($sformatf("i%0d core_state", g), core_state, exp_cs);
            chk($sformatf("i%0d core_key", g), core_key, exp_ck);
            if (rst_s[g]) begin
                q.delete();
                rr_last = 1'b1;
                exp_cs = '0;
                exp_ck = '0;
                exp_rd = '0;
            end else begin
                cap = (q.size() < M) || (q.size() > 0 && q[0].due == n + 1);
`ifdef AES_SCHED_STRICT_PRIO_EN
                g0 = v0_s[g];
                g1 = v1_s[g] && !v0_s[g];
`else
                if (v0_s[g] && v1_s[g]) begin
                    g0 = rr_last;
                    g1 = !rr_last;
                end else begin
                    g0 = v0_s[g];
                    g1 = v1_s[g];
                end
`endif
                g0 = g0 && cap;
                g1 = g1 && cap;
                chk($sformatf("i%0d req0_ready", g), 128'(r0_w[g]), 128'(g0));
                chk($sformatf("i%0d req1_ready", g), 128'(r1_w[g]), 128'(g1));
                if (g0 || g1) begin
                    e.id   = g1;
                    e.due  = n + 1 + L;
                    e.data = g1 ? f_core(s1_s[g], k1_s[g]) : f_core(s0_s[g], k0_s[g]);
                    q.push_back(e);
                    exp_cs  = g1 ? s1_s[g] : s0_s[g];
                    exp_ck  = g1 ? k1_s[g] : k0_s[g];
                    rr_last = g1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1;
            v0_s[i] = 1'b0; v1_s[i] = 1'b0;
            s0_s[i] = '0; k0_s[i] = '0; s1_s[i] = '0; k1_s[i] = '0;
        end
        repeat (2) tick();
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset inflight", 128'(inf_w[0]), 128'(0));
        chk("reset rsp_data", rd_w[0], 128'(0));
        chk("reset rsp0_valid", 128'(p0_w[0]), 128'(0));

        // Contention on instance 0
        tick();
        v0_s[0] = 1'b1; v1_s[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s0_s[0] = rnd128(); k0_s[0] = rnd128();
            s1_s[0] = rnd128(); k1_s[0] = rnd128();
            @(negedge clk);
`ifdef AES_SCHED_STRICT_PRIO_EN
            chk("prio req0_ready", 128'(r0_w[0]), 128'(1));
            chk("prio req1_ready", 128'(r1_w[0]), 128'(0));
`else
            chk("rr req0_ready", 128'(r0_w[0]), 128'(i % 2 == 0));
            chk("rr req1_ready", 128'(r1_w[0]), 128'(i % 2 == 1));
`endif
            tick();
        end
`ifdef AES_SCHED_STRICT_PRIO_EN
        v0_s[0] = 1'b0;
        @(negedge clk);
        chk("prio req1 after drop", 128'(r1_w[0]), 128'(1));
        tick();
`endif
        v0_s[0] = 1'b0; v1_s[0] = 1'b0;
        repeat (25) tick();

        // Single FIPS-197 block through instance 0
        v0_s[0] = 1'b1; s0_s[0] = PT; k0_s[0] = KEY;
        tick();
        v0_s[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("single early rsp0", 128'(p0_w[0]), 128'(0));
        @(negedge clk);
        chk("single rsp0_valid", 128'(p0_w[0]), 128'(1));
        chk("single rsp1_valid", 128'(p1_w[0]), 128'(0));
        chk("single rsp_data", rd_w[0], CT);
        @(negedge clk);
        chk("single rsp0 pulse end", 128'(p0_w[0]), 128'(0));
        chk("single inflight", 128'(inf_w[0]), 128'(0));
        tick();

        // Reset mid-flight on instance 0
        v0_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s0_s[0] = rnd128(); k0_s[0] = rnd128();
            tick();
        end
        v0_s[0] = 1'b0;
        repeat (5) tick();
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        v0_s[0] = 1'b1; v1_s[0] = 1'b1;
        @(negedge clk);
        chk("post-reset inflight", 128'(inf_w[0]), 128'(0));
        chk("post-reset req0_ready", 128'(r0_w[0]), 128'(1));
        chk("post-reset req1_ready", 128'(r1_w[0]), 128'(0));
        tick();
        v0_s[0] = 1'b0; v1_s[0] = 1'b0;
        repeat (25) tick();

        // Capacity on instance 1 (LATENCY=8, MAX_INFLIGHT=4)
        v0_s[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s0_s[1] = rnd128(); k0_s[1] = rnd128();
            @(negedge clk);
            chk("cap req0_ready", 128'(r0_w[1]), 128'((k / 4) % 2 == 0));
            chk("cap inflight", 128'(inf_w[1]), 128'((k < 4) ? k : 4));
            tick();
        end
        v0_s[1] = 1'b0;
        repeat (12) tick();

        // Randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                v0_s[i]  = ($urandom_range(0, 99) < 65);
                v1_s[i]  = ($urandom_range(0, 99) < 65);
                s0_s[i]  = rnd128(); k0_s[i] = rnd128();
                s1_s[i]  = rnd128(); k1_s[i] = rnd128();
                rst_s[i] = ($urandom_range(0, 249) == 0);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            v0_s[i] = 1'b0; v1_s[i] = 1'b0; rst_s[i] = 1'b0;
        end
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
